hpdcache_snoop_dir_ctrl: RTL and testbench

Coherence snoop controller for the HPDcache directory. It accepts snoop requests (probe, invalidate, clean) from the coherence interconnect and reads all ways of the addressed set. It compares tags, writes back the modified entry when needed, and returns a snoop response. It sits directly upstream of the directory read arbiter and drives that arbiter's coherence request port, which has absolute priority over core traffic, so the directory SRAM sees its accesses in the same cycle.

---
 rtl/hpdcache_snoop_pkg.sv | 49 ++++
 rtl/hpdcache_snoop_dir_ctrl_if.sv | 53 +++++
 rtl/hpdcache_snoop_tag_cmp.sv | 40 ++++
 rtl/hpdcache_snoop_dir_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hpdcache_snoop_dir_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hpdcache_snoop_pkg.sv
// HPDcache coherence snoop controller: shared types and sizes.
// Directory entry layout, snoop opcodes, response bundle, FSM states.
package hpdcache_snoop_pkg;

  localparam int unsigned NUM_WAYS  = 4;
  localparam int unsigned SET_WIDTH = 7;
  localparam int unsigned TAG_WIDTH = 20;
  localparam int unsigned ID_WIDTH  = 4;

  typedef enum logic [1:0] {
    SNOOP_PROBE = 2'd0,
    SNOOP_INVAL = 2'd1,
    SNOOP_CLEAN = 2'd2,
    SNOOP_RSVD  = 2'd3
  } snoop_op_e;

  typedef struct packed {
    logic                 valid;
    logic                 wback;
    logic                 dirty;
    logic                 fetch;
    logic [TAG_WIDTH-1:0] tag;
  } dir_entry_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                hit;
    logic                dirty;
    logic                retry;
    logic [NUM_WAYS-1:0] way;
  } snoop_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CMP,
    ST_WRITE,
    ST_RSP
  } snoop_state_e;

  // The reserved opcode behaves exactly like a probe
  function automatic snoop_op_e norm_op(
    input logic [1:0] op
  );
    return (op == 2'd3) ? SNOOP_PROBE
                        : snoop_op_e'(op);
  endfunction

endpackage

// File: rtl/hpdcache_snoop_dir_ctrl_if.sv
// Snoop request/response channel between the coherence
// interconnect (master) and the directory snoop controller (slave).
interface hpdcache_snoop_dir_ctrl_if;
  import hpdcache_snoop_pkg::*;

  logic                 snoop_req_valid_i;
  logic                 snoop_req_ready_o;
  logic [1:0]           snoop_req_op_i;
  logic [SET_WIDTH-1:0] snoop_req_set_i;
  logic [TAG_WIDTH-1:0] snoop_req_tag_i;
  logic [ID_WIDTH-1:0]  snoop_req_id_i;

  logic                 snoop_rsp_valid_o;
  logic                 snoop_rsp_ready_i;
  logic [ID_WIDTH-1:0]  snoop_rsp_id_o;
  logic                 snoop_rsp_hit_o;
  logic                 snoop_rsp_dirty_o;
  logic                 snoop_rsp_retry_o;
  logic [NUM_WAYS-1:0]  snoop_rsp_way_o;

  modport master (
    output snoop_req_valid_i,
    input  snoop_req_ready_o,
    output snoop_req_op_i,
    output snoop_req_set_i,
    output snoop_req_tag_i,
    output snoop_req_id_i,
    input  snoop_rsp_valid_o,
    output snoop_rsp_ready_i,
    input  snoop_rsp_id_o,
    input  snoop_rsp_hit_o,
    input  snoop_rsp_dirty_o,
    input  snoop_rsp_retry_o,
    input  snoop_rsp_way_o
  );

  modport slave (
    input  snoop_req_valid_i,
    output snoop_req_ready_o,
    input  snoop_req_op_i,
    input  snoop_req_set_i,
    input  snoop_req_tag_i,
    input  snoop_req_id_i,
    output snoop_rsp_valid_o,
    input  snoop_rsp_ready_i,
    output snoop_rsp_id_o,
    output snoop_rsp_hit_o,
    output snoop_rsp_dirty_o,
    output snoop_rsp_retry_o,
    output snoop_rsp_way_o
  );

endinterface

// File: rtl/hpdcache_snoop_tag_cmp.sv
// Per-way tag compare with lowest-index priority select,
// multi-hit detection and selected-entry mux.
module hpdcache_snoop_tag_cmp
  import hpdcache_snoop_pkg::*;
#(
  parameter int unsigned NumWays = NUM_WAYS
) (
  input  dir_entry_t [NumWays-1:0] entries_i,
  input  logic [TAG_WIDTH-1:0]     tag_i,
  output logic [NumWays-1:0]       hit_way_o,
  output logic                     hit_o,
  output logic                     multi_hit_o,
  output dir_entry_t               hit_entry_o
);

  localparam logic [NumWays-1:0] ONE = NumWays'(1);

  logic [NumWays-1:0] hit_vec;

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < NumWays; w++) begin
      hit_vec[w] = entries_i[w].valid &
                   (entries_i[w].tag == tag_i);
    end
  end

  // x & -x isolates the lowest set bit
  assign hit_way_o   = hit_vec & (~hit_vec + ONE);
  assign hit_o       = |hit_vec;
  assign multi_hit_o = |(hit_vec & (hit_vec - ONE));

  always_comb begin
    hit_entry_o = '0;
    for (int w = 0; w < NumWays; w++) begin
      if (hit_way_o[w]) hit_entry_o = entries_i[w];
    end
  end

endmodule

// File: rtl/hpdcache_snoop_dir_ctrl.sv
// Coherence snoop controller: reads a directory set, compares
// tags, optionally rewrites the hit way, and answers the snoop.
module hpdcache_snoop_dir_ctrl
  import hpdcache_snoop_pkg::*;
#(
  parameter int unsigned NumWays  = NUM_WAYS,
  parameter int unsigned SetWidth = SET_WIDTH,
  parameter int unsigned TagWidth = TAG_WIDTH,
  parameter int unsigned IdWidth  = ID_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  hpdcache_snoop_dir_ctrl_if.slave snoop,
  output logic                     coh_req_o,
  output logic [SetWidth-1:0]      coh_dir_addr_o,
  output logic [NumWays-1:0]       coh_dir_cs_o,
  output logic [NumWays-1:0]       coh_dir_we_o,
  output dir_entry_t [NumWays-1:0] coh_dir_wentry_o,
  input  dir_entry_t [NumWays-1:0] dir_rentry_i,
  output logic                     multi_hit_o
);

  snoop_state_e state_q, state_d;

  snoop_op_e           op_q;
  logic [SetWidth-1:0] set_q;
  logic [TagWidth-1:0] tag_q;
  logic [IdWidth-1:0]  id_q;
  snoop_rsp_t          rsp_q, rsp_d;
  dir_entry_t          wentry_q, wentry_d;
  logic [NumWays-1:0]  wway_q;

  logic [NumWays-1:0] hit_way;
  logic               hit;
  logic               multi_hit;
  dir_entry_t         hit_entry;
  logic               need_wr;
  logic               accept;

  hpdcache_snoop_tag_cmp #(
    .NumWays (NumWays)
  ) u_tag_cmp (
    .entries_i   (dir_rentry_i),
    .tag_i       (tag_q),
    .hit_way_o   (hit_way),
    .hit_o       (hit),
    .multi_hit_o (multi_hit),
    .hit_entry_o (hit_entry)
  );

  assign accept = snoop.snoop_req_valid_i &
                  (state_q == ST_IDLE);

  assign snoop.snoop_req_ready_o = (state_q == ST_IDLE);

  // A pending refill (fetch) blocks any update of the line
  always_comb begin
    rsp_d       = '0;
    rsp_d.id    = id_q;
    rsp_d.hit   = hit;
    rsp_d.dirty = hit_entry.dirty;
    rsp_d.retry = hit & hit_entry.fetch;
    rsp_d.way   = hit_way;

    wentry_d = hit_entry;
    unique case (1'b1)
      (op_q == SNOOP_INVAL): begin
        wentry_d.valid = 1'b0;
        wentry_d.dirty = 1'b0;
        wentry_d.wback = 1'b0;
      end
      (op_q == SNOOP_CLEAN): wentry_d.dirty = 1'b0;
      default: ;
    endcase

    need_wr = hit & ~hit_entry.fetch &
              ((op_q == SNOOP_INVAL) |
               ((op_q == SNOOP_CLEAN) & hit_entry.dirty));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (snoop.snoop_req_valid_i) state_d = ST_READ;
      ST_READ:  state_d = ST_CMP;
      ST_CMP:   state_d = need_wr ? ST_WRITE : ST_RSP;
      ST_WRITE: state_d = ST_RSP;
      ST_RSP:   if (snoop.snoop_rsp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= SNOOP_PROBE;
      set_q    <= '0;
      tag_q    <= '0;
      id_q     <= '0;
      rsp_q    <= '0;
      wentry_q <= '0;
      wway_q   <= '0;
    end else begin
      if (accept) begin
        op_q  <= norm_op(snoop.snoop_req_op_i);
        set_q <= snoop.snoop_req_set_i;
        tag_q <= snoop.snoop_req_tag_i;
        id_q  <= snoop.snoop_req_id_i;
      end
      if (state_q == ST_CMP) begin
        rsp_q    <= rsp_d;
        wentry_q <= wentry_d;
        wway_q   <= hit_way;
      end
    end
  end

  always_comb begin
    coh_req_o               = 1'b0;
    coh_dir_addr_o          = '0;
    coh_dir_cs_o            = '0;
    coh_dir_we_o            = '0;
    coh_dir_wentry_o        = '0;
    multi_hit_o             = 1'b0;
    snoop.snoop_rsp_valid_o = 1'b0;
    snoop.snoop_rsp_id_o    = '0;
    snoop.snoop_rsp_hit_o   = 1'b0;
    snoop.snoop_rsp_dirty_o = 1'b0;
    snoop.snoop_rsp_retry_o = 1'b0;
    snoop.snoop_rsp_way_o   = '0;
    unique case (state_q)
      ST_READ: begin
        coh_req_o      = 1'b1;
        coh_dir_addr_o = set_q;
        coh_dir_cs_o   = '1;
      end
      ST_CMP: multi_hit_o = multi_hit;
      ST_WRITE: begin
        coh_req_o      = 1'b1;
        coh_dir_addr_o = set_q;
        coh_dir_cs_o   = wway_q;
        coh_dir_we_o   = wway_q;
        for (int w = 0; w < NumWays; w++) begin
          if (wway_q[w]) coh_dir_wentry_o[w] = wentry_q;
        end
      end
      ST_RSP: begin
        snoop.snoop_rsp_valid_o = 1'b1;
        snoop.snoop_rsp_id_o    = rsp_q.id;
        snoop.snoop_rsp_hit_o   = rsp_q.hit;
        snoop.snoop_rsp_dirty_o = rsp_q.dirty;
        snoop.snoop_rsp_retry_o = rsp_q.retry;
        snoop.snoop_rsp_way_o   = rsp_q.way;
      end
      default: ;
    endcase
    // Reset aborts at once: nothing leaves the block that cycle
    if (rst_i) begin
      coh_req_o               = 1'b0;
      coh_dir_addr_o          = '0;
      coh_dir_cs_o            = '0;
      coh_dir_we_o            = '0;
      coh_dir_wentry_o        = '0;
      multi_hit_o             = 1'b0;
      snoop.snoop_rsp_valid_o = 1'b0;
      snoop.snoop_rsp_id_o    = '0;
      snoop.snoop_rsp_hit_o   = 1'b0;
      snoop.snoop_rsp_dirty_o = 1'b0;
      snoop.snoop_rsp_retry_o = 1'b0;
      snoop.snoop_rsp_way_o   = '0;
    end
  end

endmodule

// File: tb/tb_hpdcache_snoop_dir_ctrl.sv
// Bench for hpdcache_snoop_dir_ctrl: directed + random snoops
// against a per-cycle expected trace built from a set-level model.
module tb_hpdcache_snoop_dir_ctrl;
  import hpdcache_snoop_pkg::*;

  localparam int NW = NUM_WAYS;
  localparam int EW = $bits(dir_entry_t);
  localparam int NSETS = 2 ** SET_WIDTH;

  typedef struct packed {
    logic                 ready;
    logic                 coh;
    logic [SET_WIDTH-1:0] addr;
    logic [NW-1:0]        cs;
    logic [NW-1:0]        we;
    logic [NW*EW-1:0]     went;
    logic                 rv;
    logic [ID_WIDTH-1:0]  id;
    logic                 hit;
    logic                 dirty;
    logic                 retry;
    logic [NW-1:0]        way;
    logic                 mh;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hpdcache_snoop_dir_ctrl_if sif ();

  logic                 coh_req;
  logic [SET_WIDTH-1:0] coh_addr;
  logic [NW-1:0]        coh_cs;
  logic [NW-1:0]        coh_we;
  dir_entry_t [NW-1:0]  coh_went;
  dir_entry_t [NW-1:0]  rentry;
  logic                 multi_hit;

  hpdcache_snoop_dir_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .snoop            (sif.slave),
    .coh_req_o        (coh_req),
    .coh_dir_addr_o   (coh_addr),
    .coh_dir_cs_o     (coh_cs),
    .coh_dir_we_o     (coh_we),
    .coh_dir_wentry_o (coh_went),
    .dir_rentry_i     (rentry),
    .multi_hit_o      (multi_hit)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Directory SRAM: data one cycle after a read, junk otherwise
  dir_entry_t mem [NSETS][NW];
  logic       pl_en = 1'b0;
  int         pl_set = 0;
  dir_entry_t pl_val [NW];

  always @(posedge clk) begin
    if (coh_req && coh_cs != '0 && coh_we == '0) begin
      for (int w = 0; w < NW; w++) rentry[w] <= mem[coh_addr][w];
    end else begin
      rentry <= {$urandom, $urandom, $urandom};
    end
    for (int w = 0; w < NW; w++) begin
      if (!rst && coh_req && coh_cs[w] && coh_we[w])
        mem[coh_addr][w] <= coh_went[w];
    end
    if (pl_en) begin
      for (int w = 0; w < NW; w++) mem[pl_set][w] <= pl_val[w];
    end
  end

  obs_t       expq [int];
  int         n_cmp = 0;
  int         n_bad = 0;
  snoop_rsp_t last_rsp = '0;
  int         pin_seq = 0;
  int         pin_done = 0;
  string      pin_nm;
  logic [63:0] pin_act, pin_exp;

  always @(negedge clk) begin
    obs_t a;
    a       = '0;
    a.ready = sif.snoop_req_ready_o;
    a.coh   = coh_req;
    a.addr  = coh_addr;
    a.cs    = coh_cs;
    a.we    = coh_we;
    a.went  = coh_went;
    a.rv    = sif.snoop_rsp_valid_o;
    a.id    = sif.snoop_rsp_id_o;
    a.hit   = sif.snoop_rsp_hit_o;
    a.dirty = sif.snoop_rsp_dirty_o;
    a.retry = sif.snoop_rsp_retry_o;
    a.way   = sif.snoop_rsp_way_o;
    a.mh    = multi_hit;
    if (expq.exists(cyc)) begin
      n_cmp++;
      if (a !== expq[cyc]) begin
        n_bad++;
        $display("FAIL trace@%0d: got %h want %h",
                 cyc, a, expq[cyc]);
      end
    end
    if (a.rv && sif.snoop_rsp_ready_i) begin
      last_rsp = '{id: a.id, hit: a.hit, dirty: a.dirty,
                   retry: a.retry, way: a.way};
    end
    if (pin_seq != pin_done) begin
      pin_done = pin_seq;
      n_cmp++;
      if (pin_act !== pin_exp) begin
        n_bad++;
        $display("FAIL %s: got %h want %h",
                 pin_nm, pin_act, pin_exp);
      end
    end
  end

  dir_entry_t exp_mem [8][NW];
  logic [TAG_WIDTH-1:0] pool [4] =
    '{20'h01234, 20'h00abc, 20'hfffff, 20'h55555};

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic dir_entry_t mk(
    input bit v, input bit wb, input bit d, input bit f,
    input logic [TAG_WIDTH-1:0] tag);
    return '{valid: v, wback: wb, dirty: d, fetch: f, tag: tag};
  endfunction

  function automatic snoop_rsp_t mkr(
    input logic [ID_WIDTH-1:0] id, input bit h, input bit d,
    input bit r, input logic [NW-1:0] way);
    return '{id: id, hit: h, dirty: d, retry: r, way: way};
  endfunction

  // Set-level snoop semantics
  function automatic void model(
    input  dir_entry_t e [NW],
    input  logic [1:0] op,
    input  logic [TAG_WIDTH-1:0] tag,
    output int sel, output bit mh, output bit hit,
    output bit dirty, output bit retry, output bit wr,
    output dir_entry_t ne);
    int nh;
    nh = 0; sel = 0; mh = 0; hit = 0;
    dirty = 0; retry = 0; wr = 0; ne = '0;
    for (int w = NW - 1; w >= 0; w--) begin
      if (e[w].valid && e[w].tag == tag) begin
        nh++;
        sel = w;
      end
    end
    if (nh == 0) return;
    hit = 1; mh = (nh > 1);
    dirty = e[sel].dirty; retry = e[sel].fetch;
    ne = e[sel];
    if (retry) return;
    if (op == 2'd1) begin
      wr = 1; ne.valid = 0; ne.dirty = 0; ne.wback = 0;
    end else if (op == 2'd2 && e[sel].dirty) begin
      wr = 1; ne.dirty = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sif.snoop_req_valid_i = 1'b0;
      expq[cyc] = idle_obs();
      step();
    end
  endtask

  task automatic preload(input int set, input dir_entry_t v [NW]);
    sif.snoop_req_valid_i = 1'b0;
    pl_en = 1'b1; pl_set = set; pl_val = v;
    exp_mem[set] = v;
    expq[cyc] = idle_obs();
    step();
    pl_en = 1'b0;
  endtask

  task automatic pin(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    pin_nm = nm; pin_act = act; pin_exp = exp;
    pin_seq++;
    sif.snoop_req_valid_i = 1'b0;
    expq[cyc] = idle_obs();
    step();
  endtask

  task automatic run_txn(
    input logic [1:0] op, input int set,
    input logic [TAG_WIDTH-1:0] tag,
    input logic [ID_WIDTH-1:0] id,
    input int hold, input bit rst_wr);
    int sel, t, r, last;
    bit mh, hit, dirty, retry, wr;
    dir_entry_t ne;
    obs_t o;
    logic [NW-1:0] way;
    model(exp_mem[set], op, tag, sel, mh, hit, dirty, retry, wr, ne);
    way = '0;
    if (hit) way[sel] = 1'b1;
    t = cyc;
    r = t + (wr ? 4 : 3);
    expq[t] = idle_obs();
    o = '0; o.coh = 1; o.addr = SET_WIDTH'(set); o.cs = '1;
    expq[t+1] = o;
    o = '0; o.mh = mh;
    expq[t+2] = o;
    if (wr && !rst_wr) begin
      o = '0; o.coh = 1; o.addr = SET_WIDTH'(set);
      o.cs = way; o.we = way;
      o.went[sel*EW +: EW] = ne;
      expq[t+3] = o;
      exp_mem[set][sel] = ne;
    end
    if (!rst_wr) begin
      for (int k = 0; k <= hold; k++) begin
        o = '0; o.rv = 1; o.id = id; o.hit = hit;
        o.dirty = dirty; o.retry = retry; o.way = way;
        expq[r+k] = o;
      end
    end
    last = rst_wr ? t + 3 : r + hold;
    sif.snoop_req_valid_i = 1'b1;
    sif.snoop_req_op_i    = op;
    sif.snoop_req_set_i   = SET_WIDTH'(set);
    sif.snoop_req_tag_i   = tag;
    sif.snoop_req_id_i    = id;
    sif.snoop_rsp_ready_i = 1'($urandom);
    step();
    for (int c = t + 1; c <= last; c++) begin
      sif.snoop_req_valid_i = 1'($urandom);
      sif.snoop_req_op_i    = 2'($urandom);
      sif.snoop_req_set_i   = SET_WIDTH'($urandom);
      sif.snoop_req_tag_i   = TAG_WIDTH'($urandom);
      sif.snoop_req_id_i    = ID_WIDTH'($urandom);
      sif.snoop_rsp_ready_i = (c < r) ? 1'($urandom) : (c == last);
      rst = rst_wr && (c == t + 3);
      step();
    end
    rst = 1'b0;
    sif.snoop_req_valid_i = 1'b0;
  endtask

  initial begin
    dir_entry_t v [NW];
    snoop_rsp_t saved;
    sif.snoop_req_valid_i = 1'b0;
    sif.snoop_req_op_i    = '0;
    sif.snoop_req_set_i   = '0;
    sif.snoop_req_tag_i   = '0;
    sif.snoop_req_id_i    = '0;
    sif.snoop_rsp_ready_i = 1'b0;
    step();
    expq[cyc] = idle_obs(); step();
    expq[cyc] = idle_obs(); step();
    rst = 1'b0;

    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < NW; w++) begin
        v[w] = mk($urandom_range(0, 3) != 0, 1'($urandom),
                  1'($urandom), $urandom_range(0, 7) == 0,
                  pool[$urandom_range(0, 3)]);
      end
      preload(s, v);
    end

    v = '{mk(1,0,0,0,20'h00abc), mk(0,0,1,0,20'h01234),
          mk(1,0,1,0,20'h01234), mk(1,0,0,0,20'h55555)};
    preload(5, v);
    run_txn(2'd0, 5, 20'h01234, 4'h1, 0, 0);
    pin("probe_rsp", 64'(last_rsp), 64'(mkr(4'h1,1,1,0,4'b0100)));

    v = '{mk(1,0,0,0,20'h00abc), mk(1,1,1,0,20'h01234),
          mk(0,0,0,0,20'h01234), mk(1,0,0,0,20'h55555)};
    preload(5, v);
    run_txn(2'd1, 5, 20'h01234, 4'h2, 0, 0);
    pin("inval_rsp", 64'(last_rsp), 64'(mkr(4'h2,1,1,0,4'b0010)));
    pin("inval_entry", 64'(mem[5][1]), 64'h001234);

    v = '{mk(1,0,0,0,20'h01234), mk(1,0,1,0,20'h00abc),
          mk(0,0,0,0,20'h00000), mk(1,0,0,0,20'h55555)};
    preload(5, v);
    run_txn(2'd2, 5, 20'h01234, 4'h3, 1, 0);
    pin("clean_hit", 64'(last_rsp), 64'(mkr(4'h3,1,0,0,4'b0001)));
    run_txn(2'd2, 5, 20'habcde, 4'h4, 0, 0);
    pin("clean_miss", 64'(last_rsp), 64'(mkr(4'h4,0,0,0,4'b0000)));

    v = '{mk(1,0,0,0,20'h01234), mk(1,0,1,0,20'h00abc),
          mk(0,0,0,0,20'h01234), mk(1,0,1,0,20'h01234)};
    preload(5, v);
    run_txn(2'd3, 5, 20'h01234, 4'h5, 0, 0);
    pin("multi_hit", 64'(last_rsp), 64'(mkr(4'h5,1,0,0,4'b0001)));

    v = '{mk(1,0,0,0,20'h00abc), mk(0,0,0,0,20'h00000),
          mk(1,1,1,1,20'h01234), mk(1,0,0,0,20'h55555)};
    preload(5, v);
    run_txn(2'd1, 5, 20'h01234, 4'h6, 3, 0);
    saved = last_rsp;
    run_txn(2'd0, 5, 20'h00abc, 4'h9, 0, 0);
    pin("retry_rsp", 64'(saved), 64'(mkr(4'h6,1,1,1,4'b0100)));
    pin("retry_nowr", 64'(mem[5][2]), 64'hf01234);

    v = '{mk(1,0,0,0,20'h00abc), mk(1,0,1,0,20'h01234),
          mk(0,0,0,0,20'h00000), mk(1,0,0,0,20'h55555)};
    preload(5, v);
    run_txn(2'd1, 5, 20'h01234, 4'h7, 0, 1);
    idle(2);
    pin("rst_nowr", 64'(mem[5][1]), 64'ha01234);
    run_txn(2'd0, 5, 20'h01234, 4'h8, 0, 0);
    pin("after_rst", 64'(last_rsp), 64'(mkr(4'h8,1,1,0,4'b0010)));

    for (int i = 0; i < 60; i++) begin
      run_txn(2'($urandom), $urandom_range(0, 7),
              pool[$urandom_range(0, 3)], ID_WIDTH'($urandom),
              $urandom_range(0, 2), 0);
      idle($urandom_range(0, 2));
    end

    idle(2);
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < NW; w++) begin
        pin($sformatf("mem[%0d][%0d]", s, w),
            64'(mem[s][w]), 64'(exp_mem[s][w]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
